alu_ctl_seq: RTL and testbench
==============================

Name: alu_ctl_seq

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes funct/aluop into an ALU control code using the same code map. Sequences multi-cycle operations (muladdmod, double xor), holding the code stable and stalling the pipeline for a configurable latency.
- Adds a valid/ready issue handshake, flush, illegal-op flagging and a saturating multi-cycle-op counter.
- Sits between the ID/EX pipeline register and the ALU.

Parameters:
- CTL_W, 4, width of aluctl; must be >=4, upper bits zero-extended.
- MULADD_LAT, 3, cycles muladdmod occupies the ALU; >=1.
- DXOR_LAT, 2, cycles double xor occupies the ALU; >=1.
- STRICT, 1, when 1, R-type with funct[5:4]!=0 is flagged illegal.
- STAT_W, 8, width of multi-cycle op counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  funct/aluop valid this cycle
- in_ready  output  1  block can accept an op this cycle (combinational)
- funct  input  6  R-type function field
- aluop  input  2  main-control ALU op class
- flush  input  1  synchronous kill of the op in flight
- aluctl  output  CTL_W  registered ALU control code
- ctl_valid  output  1  aluctl is live
- op_start  output  1  first cycle of an op
- op_last  output  1  final cycle of an op
- stall  output  1  pipeline must hold (ctl_valid & ~op_last)
- illegal  output  1  current op had an unknown or disallowed funct
- multi_cnt  output  STAT_W  count of multi-cycle ops issued, saturating

Behaviour:
- Reset (async, any time, including mid-op): aluctl=0, ctl_valid=0, op_start=0, illegal=0, multi_cnt=0, internal cnt=0. Hence op_last=0, stall=0, in_ready=1.
- Decode map, applied when aluop=2, keyed on funct[3:0]:
  - 0→2 (add), 2→6 (sub), 5→1 (or), 6→13 (xor), 7→12 (nor), 10→7 (slt)
  - 3→5 (double xor), 4→8 (andor), 8→10 (muladdmod), 1→9 (xorornot)
  - other→0 with illegal=1
- Other aluop values: 0→2, 1→6, 3→2. With STRICT=1 and aluop=2, funct[5:4]!=0 forces code 0 and illegal=1.
- Latency: code 10 → MULADD_LAT; code 5 → DXOR_LAT; all others 1.
- Accept: in_valid & in_ready & ~flush. On that edge:
  - aluctl<=code, ctl_valid<=1, op_start<=1, illegal<=flag, cnt<=lat-1.
  - multi_cnt increments if lat>1, holding at all-ones once saturated.
- in_ready = ~ctl_valid | op_last. Back-to-back issue is allowed on the op_last cycle, so there is no bubble.
- While ctl_valid and cnt>0: cnt decrements each cycle, aluctl and illegal hold, op_start=0.
- op_last = ctl_valid & (cnt==0). A lat=1 op has op_start=op_last=1 in its single cycle.
- On op_last with no new accept: ctl_valid<=0, aluctl<=0, illegal<=0 next cycle.
- in_valid without ready is ignored; the upstream stage holds via stall.
- flush (priority below rst, above accept):
  - Next edge: ctl_valid=0, aluctl=0, cnt=0, illegal=0, op_start=0.
  - in_valid that cycle is dropped; multi_cnt is not decremented.
- No other internal state. Latency from accept edge to aluctl valid is one cycle.

Test Plan:
- Reset: assert rst mid-muladdmod (cnt=1) → all outputs zero immediately, before the next clk edge; in_ready=1.
- Single-cycle issue: aluop=2, funct=6'h06 → next cycle aluctl=13, ctl_valid=op_start=op_last=1, stall=0; aluctl=0 the following cycle. Repeat for aluop=0,1,3 → 2,6,2.
- Multi-cycle op: MULADD_LAT=3, funct=8 → aluctl=10 for 3 cycles, stall=1,1,0, in_ready=0,0,1. A second op (funct=0) held on in_valid is accepted on the 3rd cycle → aluctl=2 with no gap; multi_cnt=1.
- Illegal and STRICT: funct=6'h09 → aluctl=0, illegal=1. STRICT=1 with funct=6'h20 → aluctl=0, illegal=1. STRICT=0 with funct=6'h20 → aluctl=2, illegal=0.
- Flush: flush on 2nd cycle of double xor (DXOR_LAT=2) with in_valid=1 → next cycle ctl_valid=0, aluctl=0, the pending op is not accepted; the following op issues normally.
- Counter saturation: STAT_W=2, issue 5 muladdmod ops → multi_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/alu_ctl_seq.sv
// Registered ALU control sequencer: decodes funct/aluop into an ALU control code,
// holds it for multi-cycle ops, and provides issue handshake, flush and op stats.
module alu_ctl_seq #(
  parameter int CTL_W      = 4,
  parameter int MULADD_LAT = 3,
  parameter int DXOR_LAT   = 2,
  parameter int STRICT     = 1,
  parameter int STAT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [1:0]        aluop,
  input  logic              flush,
  output logic [CTL_W-1:0]  aluctl,
  output logic              ctl_valid,
  output logic              op_start,
  output logic              op_last,
  output logic              stall,
  output logic              illegal,
  output logic [STAT_W-1:0] multi_cnt
);

  localparam int MAX_LAT = (MULADD_LAT > DXOR_LAT) ? MULADD_LAT : DXOR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Returns {illegal, code}
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [5:0] f);
    logic [3:0] code;
    logic       bad;
    code = 4'd0;
    bad  = 1'b0;
    case (op)
      2'd0: code = 4'd2;
      2'd1: code = 4'd6;
      2'd3: code = 4'd2;
      default: begin
        case (f[3:0])
          4'd0:    code = 4'd2;
          4'd2:    code = 4'd6;
          4'd5:    code = 4'd1;
          4'd6:    code = 4'd13;
          4'd7:    code = 4'd12;
          4'd10:   code = 4'd7;
          4'd3:    code = 4'd5;
          4'd4:    code = 4'd8;
          4'd8:    code = 4'd10;
          4'd1:    code = 4'd9;
          default: bad  = 1'b1;
        endcase
        if ((STRICT != 0) && (f[5:4] != 2'b00)) begin
          code = 4'd0;
          bad  = 1'b1;
        end
      end
    endcase
    return {bad, code};
  endfunction

  // Extra hold cycles beyond the first for a given code
  function automatic logic [CNT_W-1:0] extra_cycles(input logic [3:0] code);
    case (code)
      4'd10:   return CNT_W'(MULADD_LAT - 1);
      4'd5:    return CNT_W'(DXOR_LAT - 1);
      default: return '0;
    endcase
  endfunction

  logic [4:0]       dec;
  logic [3:0]       dec_code;
  logic             dec_ill;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign dec      = decode(aluop, funct);
  assign dec_code = dec[3:0];
  assign dec_ill  = dec[4];
  assign dec_cnt  = extra_cycles(dec_code);

  assign op_last  = ctl_valid & (cnt == '0);
  assign stall    = ctl_valid & ~op_last;
  assign in_ready = ~ctl_valid | op_last;
  assign accept   = in_valid & in_ready & ~flush;

  // Issue / hold stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluctl    <= '0;
      ctl_valid <= 1'b0;
      op_start  <= 1'b0;
      illegal   <= 1'b0;
      multi_cnt <= '0;
      cnt       <= '0;
    end else if (flush) begin
      aluctl    <= '0;
      ctl_valid <= 1'b0;
      op_start  <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      aluctl    <= CTL_W'(dec_code);
      ctl_valid <= 1'b1;
      op_start  <= 1'b1;
      illegal   <= dec_ill;
      cnt       <= dec_cnt;
      if ((dec_cnt != '0) && (multi_cnt != '1))
        multi_cnt <= multi_cnt + STAT_W'(1);
    end else if (ctl_valid && (cnt != '0)) begin
      cnt      <= cnt - CNT_W'(1);
      op_start <= 1'b0;
    end else begin
      aluctl    <= '0;
      ctl_valid <= 1'b0;
      op_start  <= 1'b0;
      illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Bench for alu_ctl_seq: two instances (STRICT=1/STAT_W=8 and STRICT=0/STAT_W=2)
// driven in lockstep against a cycle model with an issue scoreboard.
module tb_alu_ctl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] funct;
  logic [1:0] aluop;
  logic       flush;

  logic       in_ready_a, ctl_valid_a, op_start_a, op_last_a, stall_a, illegal_a;
  logic [3:0] aluctl_a;
  logic [7:0] multi_cnt_a;
  logic       in_ready_b, ctl_valid_b, op_start_b, op_last_b, stall_b, illegal_b;
  logic [3:0] aluctl_b;
  logic [1:0] multi_cnt_b;

  always #5 clk = ~clk;

  alu_ctl_seq #(.CTL_W(4), .MULADD_LAT(3), .DXOR_LAT(2), .STRICT(1), .STAT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .funct(funct),
    .aluop(aluop), .flush(flush), .aluctl(aluctl_a), .ctl_valid(ctl_valid_a),
    .op_start(op_start_a), .op_last(op_last_a), .stall(stall_a), .illegal(illegal_a),
    .multi_cnt(multi_cnt_a)
  );

  alu_ctl_seq #(.CTL_W(4), .MULADD_LAT(3), .DXOR_LAT(2), .STRICT(0), .STAT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .funct(funct),
    .aluop(aluop), .flush(flush), .aluctl(aluctl_b), .ctl_valid(ctl_valid_b),
    .op_start(op_start_b), .op_last(op_last_b), .stall(stall_b), .illegal(illegal_b),
    .multi_cnt(multi_cnt_b)
  );

  typedef struct {
    int code_a;
    bit ill_a;
    int code_b;
    bit ill_b;
    int lat;
    int mc_a;
    int mc_b;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   rem;
  int   mc_a;
  int   mc_b;
  int   n_chk;
  int   n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f, input bit strict,
                                  output int code, output bit ill);
    code = 0;
    ill  = 1'b0;
    if (op == 2'd0 || op == 2'd3) code = 2;
    else if (op == 2'd1) code = 6;
    else begin
      case (f[3:0])
        4'h0: code = 2;
        4'h1: code = 9;
        4'h2: code = 6;
        4'h3: code = 5;
        4'h4: code = 8;
        4'h5: code = 1;
        4'h6: code = 13;
        4'h7: code = 12;
        4'h8: code = 10;
        4'hA: code = 7;
        default: ill = 1'b1;
      endcase
      if (strict && f[5:4] != 2'b00) begin
        code = 0;
        ill  = 1'b1;
      end
    end
  endfunction

  function automatic int ref_lat(input int code);
    if (code == 10) return 3;
    if (code == 5) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    rem  = 0;
    mc_a = 0;
    mc_b = 0;
    sbq.delete();
  endtask

  task automatic cycle(input bit v, input logic [1:0] op, input logic [5:0] f, input bit fl);
    exp_t e;
    bit   acc;
    bit   rdy;
    in_valid = v;
    aluop    = op;
    funct    = f;
    flush    = fl;
    rdy = (rem <= 1);
    check("in_ready_a", 32'(in_ready_a), 32'(rdy));
    check("in_ready_b", 32'(in_ready_b), 32'(rdy));
    acc = v && rdy && !fl;
    if (fl) rem = 0;
    else if (acc) begin
      ref_dec(op, f, 1'b1, e.code_a, e.ill_a);
      ref_dec(op, f, 1'b0, e.code_b, e.ill_b);
      e.lat = ref_lat(e.code_a);
      if (e.lat > 1) begin
        mc_a = (mc_a < 255) ? mc_a + 1 : 255;
        mc_b = (mc_b < 3) ? mc_b + 1 : 3;
      end
      e.mc_a = mc_a;
      e.mc_b = mc_b;
      sbq.push_back(e);
      rem = e.lat;
    end else if (rem > 0) rem--;
    @(posedge clk);
    #1;
    if (acc && sbq.size() > 0) begin
      cur = sbq.pop_front();
      check("op_start_a", 32'(op_start_a), 32'd1);
      check("ctl_valid_a", 32'(ctl_valid_a), 32'd1);
      check("aluctl_a", 32'(aluctl_a), 32'(cur.code_a));
      check("illegal_a", 32'(illegal_a), 32'(cur.ill_a));
      check("aluctl_b", 32'(aluctl_b), 32'(cur.code_b));
      check("illegal_b", 32'(illegal_b), 32'(cur.ill_b));
    end else if (rem > 0) begin
      check("hold_op_start_a", 32'(op_start_a), 32'd0);
      check("hold_ctl_valid_a", 32'(ctl_valid_a), 32'd1);
      check("hold_aluctl_a", 32'(aluctl_a), 32'(cur.code_a));
      check("hold_illegal_a", 32'(illegal_a), 32'(cur.ill_a));
    end else begin
      check("idle_ctl_valid_a", 32'(ctl_valid_a), 32'd0);
      check("idle_aluctl_a", 32'(aluctl_a), 32'd0);
      check("idle_illegal_a", 32'(illegal_a), 32'd0);
      check("idle_op_start_a", 32'(op_start_a), 32'd0);
      check("idle_aluctl_b", 32'(aluctl_b), 32'd0);
    end
    check("stall_a", 32'(stall_a), 32'(rem > 1));
    check("op_last_a", 32'(op_last_a), 32'(rem == 1));
    check("stall_b", 32'(stall_b), 32'(rem > 1));
    check("multi_cnt_a", 32'(multi_cnt_a), 32'(mc_a));
    check("multi_cnt_b", 32'(multi_cnt_b), 32'(mc_b));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_aluctl"}, 32'(aluctl_a), 32'd0);
    check({tag, "_ctl_valid"}, 32'(ctl_valid_a), 32'd0);
    check({tag, "_op_start"}, 32'(op_start_a), 32'd0);
    check({tag, "_op_last"}, 32'(op_last_a), 32'd0);
    check({tag, "_stall"}, 32'(stall_a), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_a), 32'd0);
    check({tag, "_multi_cnt_a"}, 32'(multi_cnt_a), 32'd0);
    check({tag, "_multi_cnt_b"}, 32'(multi_cnt_b), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    funct    = 6'h00;
    aluop    = 2'd0;
    flush    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    rst = 1'b0;

    // Single-cycle ops, each followed by an idle cycle
    cycle(1'b1, 2'd2, 6'h06, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);
    cycle(1'b1, 2'd0, 6'h00, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);
    cycle(1'b1, 2'd1, 6'h00, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);
    cycle(1'b1, 2'd3, 6'h00, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);

    // Muladdmod with a follow-on add held on in_valid until op_last
    cycle(1'b1, 2'd2, 6'h08, 1'b0);
    cycle(1'b1, 2'd2, 6'h00, 1'b0);
    cycle(1'b1, 2'd2, 6'h00, 1'b0);
    cycle(1'b1, 2'd2, 6'h00, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);

    // Remaining map entries, illegal funct and the STRICT split on funct[5:4]
    for (int i = 0; i < 16; i++) begin
      if (i != 3 && i != 8) begin
        cycle(1'b1, 2'd2, 6'(i), 1'b0);
        cycle(1'b0, 2'd0, 6'h00, 1'b0);
      end
    end
    cycle(1'b1, 2'd2, 6'h20, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);

    // Flush on the second cycle of double xor, with a pending op dropped
    cycle(1'b1, 2'd2, 6'h03, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);
    cycle(1'b1, 2'd2, 6'h00, 1'b1);
    cycle(1'b1, 2'd2, 6'h05, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);

    // Async reset while muladdmod has one hold cycle left
    cycle(1'b1, 2'd2, 6'h08, 1'b0);
    cycle(1'b0, 2'd0, 6'h00, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Five back-to-back muladdmods: STAT_W=2 counter saturates at 3
    for (int k = 0; k < 15; k++) cycle(1'b1, 2'd2, 6'h08, 1'b0);
    repeat (3) cycle(1'b0, 2'd0, 6'h00, 1'b0);
    check("sat_multi_cnt_b", 32'(multi_cnt_b), 32'd3);
    check("sat_multi_cnt_a", 32'(multi_cnt_a), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
